// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - shared op encodings and FSM state type for the muldiv sequencer
package muldiv_seq_pkg;

    localparam logic [1:0] MD_MUL   = 2'b00;
    localparam logic [1:0] MD_MULHU = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_REMU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_seq_step.sv
// rtl/muldiv_seq_step.sv - one combinational radix-2 shift-add multiply / restoring divide iteration
module muldiv_seq_step #(
    parameter int N = 32
) (
    input  logic         i_div,
    input  logic [N-1:0] i_hr,
    input  logic [N-1:0] i_lq,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_hr,
    output logic [N-1:0] o_lq
);

    logic [N:0] w_sum;
    logic [N:0] w_shift;
    logic [N:0] w_diff;

    assign w_sum   = {1'b0, i_hr} + (i_lq[0] ? {1'b0, i_b} : '0);
    assign w_shift = {i_hr, i_lq[N-1]};
    assign w_diff  = w_shift - {1'b0, i_b};

    // The remainder never exceeds the divisor, so the top bit of r is always
    // zero after a step and r fits in N bits.
    always_comb begin
        o_hr = '0;
        o_lq = '0;
        if (i_div) begin
            if (!w_diff[N]) begin
                o_hr = w_diff[N-1:0];
                o_lq = {i_lq[N-2:0], 1'b1};
            end else begin
                o_hr = w_shift[N-1:0];
                o_lq = {i_lq[N-2:0], 1'b0};
            end
        end else begin
            o_hr = w_sum[N:1];
            o_lq = {w_sum[0], i_lq[N-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative unsigned MUL/MULHU/DIVU/REMU sequencer with valid/ready ports
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         kill,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [N-1:0] result,
    output logic         busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_op;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_hr;
    logic [N-1:0]   r_lq;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   w_hr_nxt;
    logic [N-1:0]   w_lq_nxt;
    logic [N-1:0]   w_result;
    logic           w_accept;

    assign w_accept = (r_state == ST_IDLE) && req_valid && !kill;

    muldiv_seq_step #(.N(N)) u_step (
        .i_div (r_op[1]),
        .i_hr  (r_hr),
        .i_lq  (r_lq),
        .i_b   (r_b),
        .o_hr  (w_hr_nxt),
        .o_lq  (w_lq_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_b     <= '0;
            r_hr    <= '0;
            r_lq    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op  <= op;
                r_b   <= b;
                r_hr  <= '0;
                r_lq  <= a;
                r_cnt <= CW'(N - 1);
            end else if (r_state == ST_CALC && !kill) begin
                r_hr  <= w_hr_nxt;
                r_lq  <= w_lq_nxt;
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // kill wins over both completion and the response handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_CALC;
            ST_CALC: begin
                if (kill)               w_state_nxt = ST_IDLE;
                else if (r_cnt == '0)   w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (kill || resp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_result = '0;
        if (r_state == ST_DONE) begin
            case (r_op)
                MD_MUL:   w_result = r_lq;
                MD_MULHU: w_result = r_hr;
                MD_DIVU:  w_result = r_lq;
                default:  w_result = r_hr;
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_DONE);
    assign busy       = (r_state == ST_CALC) || (r_state == ST_DONE);
    assign result     = w_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq with directed and random operations
module tb_muldiv_seq;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         kill;
    logic         resp_valid;
    logic         resp_ready;
    logic [N-1:0] result;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [N-1:0] exp_q[$];

    muldiv_seq #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .kill       (kill),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [N-1:0] model(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
        logic [2*N-1:0] p;
        p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
        case (o)
            2'b00:   return p[N-1:0];
            2'b01:   return p[2*N-1:N];
            2'b10:   return (y == 0) ? {N{1'b1}} : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Monitor: the handshake happens on the next rising edge after this sample.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_resp: got 0x%08h expected no response", result);
            end else begin
                check("resp_result", result, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        if (!req_ready) check("idle_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic issue(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic push, input logic [N-1:0] exp);
        wait_idle();
        req_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        @(posedge clk);
        if (push) exp_q.push_back(exp);
        #1;
        req_valid = 1'b0;
        op = 2'($urandom);
        a  = $urandom;
        b  = $urandom;
    endtask

    task automatic wait_resp(output int lat, output logic saw_ready);
        lat = 0;
        saw_ready = 1'b0;
        while (!resp_valid && lat < 200) begin
            if (req_ready) saw_ready = 1'b1;
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic [N-1:0] exp, input logic chk_lat);
        int lat;
        logic sr;
        issue(o, x, y, 1'b1, exp);
        wait_resp(lat, sr);
        if (chk_lat) begin
            check("latency", lat, 32'd32);
            check("req_ready_low_in_calc", {31'd0, sr}, 32'd0);
        end else if (!resp_valid) begin
            check("resp_timeout", 32'd0, 32'd1);
        end
        wait_idle();
    endtask

    task automatic abort_checks(input string tag);
        check({tag, "_req_ready"},  {31'd0, req_ready},  32'd1);
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_busy"},       {31'd0, busy},       32'd0);
        check({tag, "_result"},     result,              32'd0);
    endtask

    initial begin
        logic [N-1:0] held;
        logic [1:0]   ro;
        logic [N-1:0] ra, rb;
        int lat;
        logic sr;
        int quiet;

        rst_n = 1'b0; req_valid = 1'b0; op = 2'b00; a = '0; b = '0;
        kill = 1'b0; resp_ready = 1'b1;
        tick(); tick();
        abort_checks("reset");
        rst_n = 1'b1;
        tick();

        run_op(2'b00, 32'd7, 32'd6, 32'h0000002A, 1'b1);
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_op(2'b01, 32'h80000000, 32'd2, 32'h00000001, 1'b0);
        run_op(2'b10, 32'd100, 32'd7, 32'h0000000E, 1'b1);
        run_op(2'b11, 32'd100, 32'd7, 32'h00000002, 1'b0);
        run_op(2'b10, 32'd5, 32'd9, 32'h00000000, 1'b0);
        run_op(2'b11, 32'd5, 32'd9, 32'h00000005, 1'b0);
        run_op(2'b10, 32'h12345678, 32'd0, 32'hFFFFFFFF, 1'b0);
        run_op(2'b11, 32'h12345678, 32'd0, 32'h12345678, 1'b0);

        // Backpressure in DONE, then an immediate second request.
        resp_ready = 1'b0;
        issue(2'b01, 32'hDEADBEEF, 32'h01234567, 1'b1, model(2'b01, 32'hDEADBEEF, 32'h01234567));
        wait_resp(lat, sr);
        held = result;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_result_stable", result, held);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        check("bp_ready_after_hs", {31'd0, req_ready}, 32'd1);
        run_op(2'b11, 32'd1000, 32'd33, 32'd10, 1'b1);

        // kill on CALC cycle 10
        issue(2'b10, 32'd100, 32'd7, 1'b0, '0);
        repeat (9) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        abort_checks("kill_calc");
        quiet = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (resp_valid) quiet++;
        end
        check("kill_calc_no_resp", quiet, 32'd0);
        run_op(2'b10, 32'd100, 32'd7, 32'd14, 1'b1);

        // kill in DONE while the consumer is stalled
        resp_ready = 1'b0;
        issue(2'b10, 32'd100, 32'd7, 1'b0, '0);
        wait_resp(lat, sr);
        check("kill_done_reached", {31'd0, resp_valid}, 32'd1);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        resp_ready = 1'b1;
        abort_checks("kill_done");
        run_op(2'b10, 32'd100, 32'd7, 32'd14, 1'b1);

        // reset for one cycle in the middle of CALC
        issue(2'b00, 32'hCAFEF00D, 32'h1234, 1'b0, '0);
        repeat (12) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        abort_checks("rst_calc");
        run_op(2'b10, 32'd100, 32'd7, 32'd14, 1'b1);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 20);
            run_op(ro, ra, rb, model(ro, ra, rb), 1'b0);
        end

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
